// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: bubble encoding, fetch FSM states and
// the J-type target builder.
package mips_pkg;

  localparam logic [5:0]  OPC_NOP   = 6'b111000;
  localparam logic [31:0] NOP_INSTR = {OPC_NOP, 26'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational redirect-target mux (branch over jump) and sequential PC+4.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_pc_plus4_id,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_target_misaligned,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] w_jump_target;

  assign w_jump_target       = jump_target(i_pc_plus4_id, i_jump_index);
  assign o_redirect          = i_branch_taken | i_jump;
  assign o_target            = i_branch_taken ? i_branch_target : w_jump_target;
  assign o_target_misaligned = |o_target[1:0];
  assign o_pc_plus4          = i_pc + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding imem
// handshake and feeds IF/ID. Optional macro: FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] pc_plus4_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misaligned_pc,
`endif
  output logic        fetch_valid
);

  mips_pkg::fetch_state_t r_state, w_state_nxt;

  logic [31:0] r_pc, r_stale_addr, r_buf, r_instr, r_pc_out;
  logic        r_valid;
  logic        w_redirect, w_target_mis, w_bad, w_redir_ok, w_parked;
  logic [31:0] w_target, w_pc_plus4, w_addr;

  pc_next_sel u_next_sel (
    .i_pc                (r_pc),
    .i_branch_taken      (branch_taken),
    .i_branch_target     (branch_target),
    .i_jump              (jump),
    .i_jump_index        (jump_index),
    .i_pc_plus4_id       (pc_plus4_id),
    .o_redirect          (w_redirect),
    .o_target            (w_target),
    .o_target_misaligned (w_target_mis),
    .o_pc_plus4          (w_pc_plus4)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misaligned;

  // A misaligned redirect still kills the pending instruction but is never loaded.
  assign w_bad    = w_redirect & w_target_mis;
  assign w_parked = r_misaligned | w_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_misaligned <= 1'b0;
    else if (w_bad) r_misaligned <= 1'b1;
  end

  assign misaligned_pc = r_misaligned;
`else
  assign w_bad    = 1'b0;
  assign w_parked = 1'b0;
`endif

  assign w_redir_ok = w_redirect & ~w_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= mips_pkg::ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      mips_pkg::ST_IDLE:
        w_state_nxt = w_parked ? mips_pkg::ST_IDLE : mips_pkg::ST_REQ;
      mips_pkg::ST_REQ:
        if (imem_ready) begin
          if (w_bad)                   w_state_nxt = mips_pkg::ST_IDLE;
          else if (!w_redirect && stall) w_state_nxt = mips_pkg::ST_HOLD;
        end else if (w_redirect) begin
          w_state_nxt = mips_pkg::ST_DRAIN;
        end
      mips_pkg::ST_HOLD:
        if (w_bad)                    w_state_nxt = mips_pkg::ST_IDLE;
        else if (w_redirect || !stall) w_state_nxt = mips_pkg::ST_REQ;
      mips_pkg::ST_DRAIN:
        if (imem_ready)
          w_state_nxt = w_parked ? mips_pkg::ST_IDLE : mips_pkg::ST_REQ;
      default: w_state_nxt = mips_pkg::ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (r_state == mips_pkg::ST_REQ) || (r_state == mips_pkg::ST_DRAIN);
    w_addr   = (r_state == mips_pkg::ST_DRAIN) ? r_stale_addr : r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    imem_addr = w_addr;
`else
    imem_addr = {w_addr[31:2], 2'b00};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_buf        <= NOP_INSTR;
      r_instr      <= NOP_INSTR;
      r_pc_out     <= 32'd0;
      r_valid      <= 1'b0;
    end else begin
      // The address of an in-flight request is remembered so DRAIN can keep it stable.
      if (r_state == mips_pkg::ST_REQ) r_stale_addr <= r_pc;
      if (w_redir_ok) r_pc <= w_target;
      if (w_bad) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
      case (r_state)
        mips_pkg::ST_REQ:
          if (imem_ready) begin
            if (w_redirect) begin
              r_instr <= NOP_INSTR;
              r_valid <= 1'b0;
            end else if (stall) begin
              r_buf <= imem_rdata;
            end else begin
              r_instr  <= imem_rdata;
              r_pc_out <= w_pc_plus4;
              r_valid  <= 1'b1;
              r_pc     <= w_pc_plus4;
            end
          end else if (!stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        mips_pkg::ST_HOLD:
          if (w_redirect) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (!stall) begin
            r_instr  <= r_buf;
            r_pc_out <= w_pc_plus4;
            r_valid  <= 1'b1;
            r_pc     <= w_pc_plus4;
          end
        mips_pkg::ST_DRAIN:
          if (!stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign Instruction_out = r_instr;
  assign PC_out          = r_pc_out;
  assign fetch_valid     = r_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; memory words come from a small lookup
// (0x0, 0x4 fixed, otherwise addr ^ 0xA5A5_0000).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc_plus4_id;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] Instruction_out;
  logic [31:0] PC_out;
  logic        fetch_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misaligned_pc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'hE000_0000;

  pc_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_index      (jump_index),
    .pc_plus4_id     (pc_plus4_id),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .Instruction_out (Instruction_out),
    .PC_out          (PC_out),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned_pc   (misaligned_pc),
`endif
    .fetch_valid     (fetch_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_rdata = 32'h2008_0001;
      32'h0000_0004: imem_rdata = 32'h2009_0002;
      default:       imem_rdata = imem_addr ^ 32'hA5A5_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [31:0] instr,
                      input logic [31:0] pcout, input logic vld);
    check({tag, ".instr"}, Instruction_out, instr);
    check({tag, ".pc_out"}, PC_out, pcout);
    check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, vld});
  endtask

  task automatic req(input string tag, input logic r, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_index = '0; pc_plus4_id = '0; imem_ready = 1'b1;
    repeat (2) tick();
    outs("reset", NOP, 32'd0, 1'b0);
    req("reset", 1'b0, 32'd0);
    reset = 1'b1;

    // Straight-line fetch with memory always ready
    tick(); req("idle2req", 1'b1, 32'h0); outs("idle2req", NOP, 32'd0, 1'b0);
    tick(); outs("w0", 32'h2008_0001, 32'h4, 1'b1); req("w0", 1'b1, 32'h4);
    tick(); outs("w1", 32'h2009_0002, 32'h8, 1'b1); req("w1", 1'b1, 32'h8);

    // Memory wait states on 0x8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); outs("wait", NOP, 32'h8, 1'b0); req("wait", 1'b1, 32'h8);
    end
    imem_ready = 1'b1;
    tick(); outs("w8", 32'hA5A5_0008, 32'hC, 1'b1); req("w8", 1'b1, 32'hC);
    tick(); outs("wC", 32'hA5A5_000C, 32'h10, 1'b1); req("wC", 1'b1, 32'h10);

    // Stall while 0x10 returns
    stall = 1'b1;
    tick(); outs("hold1", 32'hA5A5_000C, 32'h10, 1'b1); req("hold1", 1'b0, 32'h10);
    tick(); outs("hold2", 32'hA5A5_000C, 32'h10, 1'b1); req("hold2", 1'b0, 32'h10);
    stall = 1'b0;
    tick(); outs("w10", 32'hA5A5_0010, 32'h14, 1'b1); req("w10", 1'b1, 32'h14);
    tick(); outs("w14", 32'hA5A5_0014, 32'h18, 1'b1); req("w14", 1'b1, 32'h18);

    // Branch while 0x18 is pending: drain the stale request
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick(); outs("drain", NOP, 32'h18, 1'b0); req("drain", 1'b1, 32'h18);
    branch_taken = 1'b0; imem_ready = 1'b1;
    tick(); outs("drained", NOP, 32'h18, 1'b0); req("drained", 1'b1, 32'h40);
    tick(); outs("w40", 32'hA5A5_0040, 32'h44, 1'b1); req("w40", 1'b1, 32'h44);

    // Jump target from pc_plus4_id upper nibble
    jump = 1'b1; jump_index = 26'h000_0010; pc_plus4_id = 32'h9000_0008;
    tick(); outs("jump", NOP, 32'h44, 1'b0); req("jump", 1'b1, 32'h9000_0040);
    jump = 1'b0;
    tick(); outs("wJ", 32'h35A5_0040, 32'h9000_0044, 1'b1);

    // PC+4 wraps past the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick(); req("br_top", 1'b1, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick(); outs("wrap", 32'h5A5A_FFFC, 32'h0, 1'b1); req("wrap", 1'b1, 32'h0);

    // Branch wins over a simultaneous jump
    branch_taken = 1'b1; branch_target = 32'h80;
    jump = 1'b1; jump_index = 26'h3FF; pc_plus4_id = 32'h0;
    tick(); req("br_vs_j", 1'b1, 32'h80); outs("br_vs_j", NOP, 32'h0, 1'b0);
    branch_taken = 1'b0; jump = 1'b0;

    // Redirect accepted during a stall kills the buffered word
    stall = 1'b1;
    tick(); req("hold_b", 1'b0, 32'h80);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick(); req("hold_redir", 1'b1, 32'h100); outs("hold_redir", NOP, 32'h0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    tick(); req("pend", 1'b1, 32'h100);

    // Asynchronous reset in the middle of a request
    reset = 1'b0;
    #1;
    req("rst_mid", 1'b0, 32'h0); outs("rst_mid", NOP, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    tick(); req("restart", 1'b1, 32'h0);
    imem_ready = 1'b1;
    tick(); outs("restart_w0", 32'h2008_0001, 32'h4, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    branch_taken = 1'b1; branch_target = 32'h42;
    tick(); check("misaligned", {31'd0, misaligned_pc}, 32'd1);
    outs("misaligned", NOP, 32'h4, 1'b0);
    branch_taken = 1'b0;
    tick(); req("parked", 1'b0, 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding instruction-memory request handshake.
- Applies branch/jump redirects from ID and honours the hazard-unit stall.
- Produces Instruction_out and PC_out (PC+4) for IF/ID. Inserts the NOP 0xE0000000 (opcode 111000) whenever no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'hE000_0000, bubble instruction; opcode 111000 is the control-unit default.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  from hazard unit, same net as IF/ID enable; 1 = hold fetch
- branch_taken  in  1  ID-stage branch resolved taken
- branch_target  in  32  branch destination
- jump  in  1  ID-stage J-type jump
- jump_index  in  26  instruction[25:0] of the jump
- pc_plus4_id  in  32  PC+4 of the ID-stage instruction (upper bits for jump target)
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_rdata  in  32  instruction, valid when imem_ready=1
- imem_ready  in  1  completes the current request
- Instruction_out  out  32  to IF/ID Instruction_in
- PC_out  out  32  to IF/ID PC_in (fetch PC + 4)
- fetch_valid  out  1  Instruction_out is a real fetched instruction

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=IDLE.
  - Instruction_out=NOP_INSTR, PC_out=0, fetch_valid=0, imem_req=0, imem_addr=RESET_PC.
- Redirect target:
  - branch_taken=1 → branch_target.
  - Else jump=1 → {pc_plus4_id[31:28], jump_index, 2'b00}.
  - Branch wins if both are asserted.
  - redirect = branch_taken | jump.
- Arithmetic: pc+4 is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- FSM states IDLE, REQ, HOLD, DRAIN. Registered outputs, one-cycle latency from imem_ready to Instruction_out.
- IDLE:
  - imem_req=0.
  - Next cycle → REQ. A redirect in IDLE loads pc=target first.
- REQ:
  - imem_req=1, imem_addr=pc.
  - ready & redirect: discard rdata; pc<=target; Instruction_out<=NOP, fetch_valid<=0; stay REQ.
  - ready & stall & !redirect: buf<=rdata; outputs hold; → HOLD.
  - ready & !stall & !redirect: Instruction_out<=rdata, PC_out<=pc+4, fetch_valid<=1, pc<=pc+4; stay REQ.
  - !ready & redirect: pc<=target; → DRAIN. The old address stays on imem_addr until it completes.
  - !ready, no redirect: if !stall, Instruction_out<=NOP, fetch_valid<=0; if stall, outputs hold.
- HOLD:
  - imem_req=0; all outputs hold.
  - !stall: Instruction_out<=buf, PC_out<=pc+4, fetch_valid<=1, pc<=pc+4; → REQ.
  - redirect (has priority over the !stall release): drop buf; pc<=target; Instruction_out<=NOP, fetch_valid<=0; → REQ.
- DRAIN:
  - imem_req=1 with the stale address.
  - On ready: discard rdata; → REQ with the new pc.
  - A further redirect in DRAIN overwrites pc only.
- Stall rules:
  - stall=1 never changes pc except by redirect.
  - stall=1 never advances outputs.
  - A redirect during stall is accepted; the pending instruction is killed.
- Single outstanding request only. imem_addr never changes while imem_req=1 and imem_ready=0.
- Reset mid-request: request dropped immediately (imem_req=0); the memory side must tolerate an abandoned request.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_pc (1 bit, reset 0), sticky until reset.
  - Set when a redirect target has bits [1:0]≠0.
  - The target is not loaded; pc holds, fetch_valid=0, NOP is emitted, FSM parks in IDLE.
- Not defined:
  - Port absent; targets are loaded as given.
  - imem_addr forces bits [1:0]=2'b00.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR constant 32'hE000_0000.
  - OPC_NOP 6'b111000.
  - Fetch FSM state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3).
  - Jump-target construction function.
- One natural sub-module: pc_next_sel, the combinational next-PC/redirect-target mux. The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset release, imem_ready tied 1, words 0x20080001, 0x20090002 → Instruction_out sequence 0x20080001, 0x20090002; PC_out 4, 8; fetch_valid=1 from the 2nd cycle after release.
- imem_ready low for 3 cycles on address 0x8 → imem_addr stable 0x8; Instruction_out=0xE0000000, fetch_valid=0 for 3 cycles; then the word at 0x8, PC_out=0xC.
- stall=1 for 2 cycles while the word at 0x10 returns → outputs hold, no new request; on stall=0 the word at 0x10 is presented with PC_out=0x14.
- branch_taken with target 0x40 while the request for 0x18 is pending → DRAIN; 0x18 discarded; next imem_addr=0x40; no fetch_valid for 0x18.
- jump, jump_index=26'h0000010, pc_plus4_id=0x9000_0008 → next imem_addr=0x9000_0040.
- Assert reset mid-REQ → imem_req=0 and Instruction_out=0xE0000000 immediately; fetch restarts at RESET_PC. With FETCH_ALIGN_CHECK_EN, branch_target=0x42 → misaligned_pc=1 and pc unchanged.
